// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 @ 60 Hz timing constants, counter type and decode helper.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC - 1;

    // True when lo <= c <= hi.
    function automatic logic in_range(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: raster timing bundle from the sync generator to the pixel stage.
interface vga_if;
    import vga_pkg::*;

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic video_on;
    logic h_sync;
    logic v_sync;

    modport master (
        output h_cnt,
        output v_cnt,
        output video_on,
        output h_sync,
        output v_sync
    );

    modport slave (
        input h_cnt,
        input v_cnt,
        input video_on,
        input h_sync,
        input v_sync
    );

endinterface

// File: rtl/vga_sync.sv
// vga_sync: h/v raster counters, registered sync pulses and video_on decode.
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    vga_if.master bus
);

    localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t H_SYNC_S = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t H_SYNC_E = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam cnt_t V_SYNC_S = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t V_SYNC_E = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    cnt_t h_nxt;
    cnt_t v_nxt;

    // Next-state counters: h wraps at H_LAST, v advances only on that wrap.
    always_comb begin
        h_nxt = bus.h_cnt;
        v_nxt = bus.v_cnt;
        if (!rst) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (bus.h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (bus.v_cnt == V_LAST) ? '0 : bus.v_cnt + 1'b1;
        end else begin
            h_nxt = bus.h_cnt + 1'b1;
        end
    end

    // video_on is decoded from the next-state counters so that a register
    // fed by it lines up with h_cnt/v_cnt after the same edge.
    assign bus.video_on = (h_nxt < H_VIS) && (v_nxt < V_VIS);

    // Counter and sync registers; sync decoded from next state for zero latency.
    always_ff @(posedge clk) begin
        bus.h_cnt <= h_nxt;
        bus.v_cnt <= v_nxt;
        if (!rst) begin
            bus.h_sync <= ~SYNC_POL;
            bus.v_sync <= ~SYNC_POL;
        end else begin
            bus.h_sync <= in_range(h_nxt, H_SYNC_S, H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
            bus.v_sync <= in_range(v_nxt, V_SYNC_S, V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_top.sv
// vga_top: 640x480 colour-bar generator; switch-selected colours in the visible area.
module vga_top
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw,
    output logic       h_sync,
    output logic       v_sync,
    output logic       red,
    output logic       green,
    output logic       blue
);

    vga_if sync_bus ();

    vga_sync #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .SYNC_POL  (SYNC_POL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .bus (sync_bus)
    );

    assign h_sync = sync_bus.h_sync;
    assign v_sync = sync_bus.v_sync;

    // Colour registers: switches gated by visible area, sampled every clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= sw[2] & sync_bus.video_on;
            green <= sw[1] & sync_bus.video_on;
            blue  <= sw[0] & sync_bus.video_on;
        end
    end

endmodule

// File: tb/tb_vga_top.sv
// tb_vga_top: directed checks of reset, sync timing, colour gating and mid-frame reset.
module tb_vga_top;

    // Full horizontal timing; vertical shortened to 6+2+2+3 = 13 lines.
    localparam int HT     = 800;
    localparam int VVIS   = 6;
    localparam int VT     = 13;
    localparam int LIMIT  = 30000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sw  = 3'b000;
    logic       h_sync, v_sync, red, green, blue;

    int total = 0;
    int bad   = 0;
    int hc    = 0;
    int vc    = 0;

    vga_if mon ();

    assign mon.h_cnt    = 10'(hc);
    assign mon.v_cnt    = 10'(vc);
    assign mon.video_on = (hc < 640) && (vc < VVIS);
    assign mon.h_sync   = h_sync;
    assign mon.v_sync   = v_sync;

    vga_top #(
        .V_VISIBLE (6),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .red    (red),
        .green  (green),
        .blue   (blue)
    );

    always #20 clk = ~clk;

    // One rising edge; the bench's own raster position follows it.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            hc = 0;
            vc = 0;
        end else if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end else begin
            hc = hc + 1;
        end
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hc == h && vc == v) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            bad++;
            $display("FAIL run_to_timeout target=%0d,%0d", h, v);
        end
    endtask

    task automatic test_reset();
        sw = 3'b111;
        apply_reset(5);
        total++;
        if (h_sync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", h_sync); end
        total++;
        if (v_sync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", v_sync); end
        total++;
        if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL reset_rgb got=%b want=000", {red, green, blue});
        end
        tick();
        total++;
        if ({red, green, blue} !== 3'b111) begin
            bad++; $display("FAIL release_rgb got=%b want=111", {red, green, blue});
        end
    endtask

    task automatic test_hsync();
        int n, w, p;
        apply_reset(2);
        n = 0;
        while (h_sync !== 1'b0 && n < LIMIT) begin tick(); n++; end
        total++;
        if (n !== 656) begin bad++; $display("FAIL hsync_first_fall got=%0d want=656", n); end
        w = 0;
        while (h_sync === 1'b0 && w < LIMIT) begin tick(); w++; end
        total++;
        if (w !== 96) begin bad++; $display("FAIL hsync_width got=%0d want=96", w); end
        p = 0;
        while (h_sync !== 1'b0 && p < LIMIT) begin tick(); p++; end
        total++;
        if (w + p !== 800) begin bad++; $display("FAIL hsync_period got=%0d want=800", w + p); end
    endtask

    task automatic test_vsync();
        int n, w, p;
        apply_reset(2);
        n = 0;
        while (v_sync !== 1'b0 && n < LIMIT) begin tick(); n++; end
        total++;
        if (n !== 6400) begin bad++; $display("FAIL vsync_first_fall got=%0d want=6400", n); end
        w = 0;
        while (v_sync === 1'b0 && w < LIMIT) begin tick(); w++; end
        total++;
        if (w !== 1600) begin bad++; $display("FAIL vsync_width got=%0d want=1600", w); end
        p = 0;
        while (v_sync !== 1'b0 && p < LIMIT) begin tick(); p++; end
        total++;
        if (w + p !== 10400) begin bad++; $display("FAIL vsync_period got=%0d want=10400", w + p); end
    endtask

    task automatic test_red_frame();
        int rc = 0, gb = 0, mism = 0, blank_hi = 0, l0 = 0;
        sw = 3'b100;
        apply_reset(2);
        repeat (HT * VT) begin
            tick();
            if (red === 1'b1) rc++;
            if (green !== 1'b0 || blue !== 1'b0) gb++;
            if (red !== mon.video_on) mism++;
            if (!mon.video_on && red !== 1'b0) blank_hi++;
            if (vc == 0 && red === 1'b1) l0++;
        end
        total++;
        if (rc !== 3840) begin bad++; $display("FAIL red_frame_count got=%0d want=3840", rc); end
        total++;
        if (l0 !== 640) begin bad++; $display("FAIL red_line0_count got=%0d want=640", l0); end
        total++;
        if (gb !== 0) begin bad++; $display("FAIL red_frame_green_blue got=%0d want=0", gb); end
        total++;
        if (blank_hi !== 0) begin bad++; $display("FAIL red_in_blanking got=%0d want=0", blank_hi); end
        total++;
        if (mism !== 0) begin bad++; $display("FAIL red_vs_visible got=%0d want=0", mism); end
    endtask

    task automatic test_colour_switch();
        sw = 3'b100;
        apply_reset(2);
        run_to(100, 1);
        total++;
        if ({red, green, blue} !== 3'b100) begin
            bad++; $display("FAIL sw_red got=%b want=100", {red, green, blue});
        end
        sw = 3'b010;
        total++;
        if ({red, green, blue} !== 3'b100) begin
            bad++; $display("FAIL sw_before_edge got=%b want=100", {red, green, blue});
        end
        tick();
        total++;
        if ({red, green, blue} !== 3'b010) begin
            bad++; $display("FAIL sw_green got=%b want=010", {red, green, blue});
        end
        run_to(300, 2);
        sw = 3'b001;
        tick();
        total++;
        if ({red, green, blue} !== 3'b001) begin
            bad++; $display("FAIL sw_blue got=%b want=001", {red, green, blue});
        end
        sw = 3'b000;
        tick();
        total++;
        if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL sw_black got=%b want=000", {red, green, blue});
        end
        sw = 3'b111;
        tick();
        total++;
        if ({red, green, blue} !== 3'b111) begin
            bad++; $display("FAIL sw_white got=%b want=111", {red, green, blue});
        end
        run_to(639, 2);
        total++;
        if ({red, green, blue} !== 3'b111) begin
            bad++; $display("FAIL last_visible_pixel got=%b want=111", {red, green, blue});
        end
        tick();
        total++;
        if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL first_hblank_pixel got=%b want=000", {red, green, blue});
        end
        run_to(10, 7);
        total++;
        if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL vblank_rgb got=%b want=000", {red, green, blue});
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, vlow = 0;
        sw = 3'b111;
        apply_reset(2);
        run_to(200, 4);
        total++;
        if ({red, green, blue} !== 3'b111) begin
            bad++; $display("FAIL mid_pre_rgb got=%b want=111", {red, green, blue});
        end
        run_to(100, 9);
        total++;
        if (v_sync !== 1'b0) begin bad++; $display("FAIL mid_pre_vsync got=%b want=0", v_sync); end
        rst = 1'b0;
        tick();
        total++;
        if (v_sync !== 1'b1) begin bad++; $display("FAIL mid_reset_vsync got=%b want=1", v_sync); end
        total++;
        if (h_sync !== 1'b1) begin bad++; $display("FAIL mid_reset_hsync got=%b want=1", h_sync); end
        total++;
        if ({red, green, blue} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_rgb got=%b want=000", {red, green, blue});
        end
        tick();
        rst = 1'b1;
        while (h_sync !== 1'b0 && n < LIMIT) begin
            tick();
            n++;
            if (v_sync !== 1'b1) vlow++;
        end
        total++;
        if (n !== 656) begin bad++; $display("FAIL mid_hsync_fall got=%0d want=656", n); end
        total++;
        if (vlow !== 0) begin bad++; $display("FAIL mid_vsync_extended got=%0d want=0", vlow); end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_vsync();
        test_red_frame();
        test_colour_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_top.md
Name: vga_top

Overview:
- Top-level VGA colour-bar generator for 640x480 @ 60 Hz, driven directly by a 25 MHz pixel clock on clk.
- Produces horizontal and vertical sync, plus 1-bit red/green/blue outputs.
- During the visible area each colour output follows its switch input; during blanking all colours are 0.
- Sits at the FPGA top level, connected to board switches and the VGA connector.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks); H_TOTAL = 800
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525
- SYNC_POL, 0, active level of h_sync/v_sync (0 = active-low)

Ports:
- clk  input  1  pixel clock, 25 MHz; all logic is on its rising edge
- rst  input  1  synchronous, active-low reset
- sw  input  3  colour select: sw[2]=red, sw[1]=green, sw[0]=blue
- h_sync  output  1  horizontal sync
- v_sync  output  1  vertical sync
- red  output  1  red pixel
- green  output  1  green pixel
- blue  output  1  blue pixel

Behaviour:
- Reset: on a rising edge with rst=0:
  - h_cnt=0, v_cnt=0.
  - h_sync and v_sync go to the inactive level (1).
  - red, green, blue go to 0.
- h_cnt (10-bit) increments by 1 every clock, 0..799; at 799 it wraps to 0.
- v_cnt (10-bit) increments only when h_cnt wraps from 799 to 0, range 0..524.
  - When h_cnt=799 and v_cnt=524 on the same clock, both wrap to 0.
- Horizontal regions:
  - Visible: h_cnt 0..639.
  - Sync active: h_cnt 656..751.
- Vertical regions:
  - Visible: v_cnt 0..479.
  - Sync active: v_cnt 490..491.
- video_on = (h_cnt<640) && (v_cnt<480).
- Output registration:
  - All outputs are registered.
  - Their values are decoded from the next-state counters, so each output reflects the counter value it is aligned with: zero latency relative to h_cnt/v_cnt.
- Colours:
  - red = sw[2] & video_on; green = sw[1] & video_on; blue = sw[0] & video_on.
  - sw is sampled on every clock, with no frame-boundary latching.
  - A change on sw appears on the colour outputs at the next rising edge inside the visible area.
- Timing summary:
  - h_sync pulse is 96 clocks wide, period 800 clocks.
  - v_sync pulse is 2 lines (1600 clocks) wide, period 525 lines (420000 clocks = 16.8 ms).
- Reset mid-frame: counters restart at 0,0 on the next edge; no partial sync pulse is extended.
- When rst returns to 1, counting resumes from 0,0 on the following edge.
- sw combinations: any combination is valid. sw=111 gives white, sw=000 gives black.

Decomposition:
- Package vga_pkg holds:
  - the eight timing constants and the derived H_TOTAL/V_TOTAL;
  - the sync start/end values (H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1, and the vertical equivalents);
  - the counter width constant (10).
- One sub-module, vga_sync, contains the h/v counters, sync generation and video_on.
  - It exports h_cnt, v_cnt and video_on.
- vga_top instantiates vga_sync and adds the colour gating and output registers.

Test Plan:
- Reset: hold rst=0 for 5 clocks -> h_sync=1, v_sync=1, red=green=blue=0. After release, h_cnt counts from 0.
- Horizontal timing: after reset, measure h_sync -> falling edge 656 clocks after release, low for exactly 96 clocks, period 800 clocks.
- Vertical timing: run 2 frames -> v_sync low for exactly 1600 clocks, period 420000 clocks. Falling edge coincides with h_cnt=0, v_cnt=490.
- Red frame: sw=100 for one frame -> red=1 for exactly 640 clocks per line on lines 0..479 (307200 clocks per frame). green=blue=0 throughout. red=0 in all blanking.
- Colour switch: sw 100 -> 010 -> 001 at arbitrary mid-line points -> only the selected colour is high in the visible area, with the change visible 1 clock after the sw edge. sw=000 -> all colours 0.
- Reset mid-frame: assert rst=0 at v_cnt=300 -> all outputs return to reset values next edge. After release, the next h_sync falling edge occurs 656 clocks later.
